// File: rtl/rx_bit_timer_gen.sv
// Receiver bit timer: per-bit shift strobes (optional mid-bit first sample) and an end-of-packet pulse.
// Define RX_TIMER_PARITY_EN to add the parity_en_i port and one parity slot ahead of the stop bit(s).
module rx_bit_timer_gen #(
    parameter int CNT_W      = 14,
    parameter int SIZE_W     = 4,
    parameter int DEF_PERIOD = 10,
    parameter int DEF_SIZE   = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_timer_i,
    input  logic [CNT_W-1:0]  bit_period_i,
    input  logic [SIZE_W-1:0] data_size_i,
    input  logic              two_stop_i,
    input  logic              mid_sample_i,
`ifdef RX_TIMER_PARITY_EN
    input  logic              parity_en_i,
`endif
    output logic              shift_enable_o,
    output logic              packet_done_o,
    output logic [SIZE_W+1:0] bit_index_o,
    output logic              busy_o
);

    localparam int NW = SIZE_W + 2;
    // One extra bit so P + P/2 never wraps.
    localparam int TW = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, FIRST, RUN, DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [TW-1:0]     tfirst_q, tfirst_d;
    logic [NW-1:0]     nbits_q, nbits_d;
    logic [TW-1:0]     cnt_q, cnt_d;
    logic [NW-1:0]     idx_q, idx_d;
    logic              shift_q, shift_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic [CNT_W-1:0]  p_sel, p_eff;
    logic [SIZE_W-1:0] d_sel;
    logic [NW-1:0]     n_new;
    logic [TW-1:0]     t_new;
    logic [TW-1:0]     cnt_inc;
    logic              last_bit;

    // Frame configuration as it would be latched at the start edge.
    always_comb begin
        p_sel = (bit_period_i == '0) ? CNT_W'(DEF_PERIOD) : bit_period_i;
        p_eff = (p_sel == CNT_W'(1)) ? CNT_W'(2) : p_sel;
        d_sel = (data_size_i == '0) ? SIZE_W'(DEF_SIZE) : data_size_i;
        n_new = NW'(d_sel) + NW'(1) + NW'(two_stop_i);
`ifdef RX_TIMER_PARITY_EN
        n_new = n_new + NW'(parity_en_i);
`endif
        t_new = mid_sample_i ? (TW'(p_eff) + TW'(p_eff >> 1)) : TW'(p_eff);
    end

    assign cnt_inc  = cnt_q + TW'(1);
    // Strobes are at least two cycles apart, so idx_q is settled whenever a strobe fires.
    assign last_bit = ((idx_q + NW'(1)) == nbits_q);

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        tfirst_d = tfirst_q;
        nbits_d  = nbits_q;
        cnt_d    = cnt_q;
        shift_d  = 1'b0;
        done_d   = 1'b0;
        idx_d    = idx_q + NW'(shift_q);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable_timer_i) begin
                    state_d  = FIRST;
                    period_d = p_eff;
                    tfirst_d = t_new;
                    nbits_d  = n_new;
                end
            end
            FIRST: begin
                if (!enable_timer_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_inc == tfirst_q) begin
                    shift_d = 1'b1;
                    cnt_d   = '0;
                    state_d = last_bit ? DONE : RUN;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RUN: begin
                if (!enable_timer_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_inc == TW'(period_q)) begin
                    shift_d = 1'b1;
                    cnt_d   = '0;
                    state_d = last_bit ? DONE : RUN;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DONE: begin
                cnt_d  = '0;
                // The final strobe is still visible on shift_q during the first DONE cycle.
                done_d = shift_q;
                if (!enable_timer_i) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (state_d == IDLE) idx_d = '0;
        busy_d = (state_d == FIRST) || (state_d == RUN);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            period_q <= '0;
            tfirst_q <= '0;
            nbits_q  <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            tfirst_q <= tfirst_d;
            nbits_q  <= nbits_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign shift_enable_o = shift_q;
    assign packet_done_o  = done_q;
    assign bit_index_o    = idx_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_rx_bit_timer_gen.sv
// Bench for rx_bit_timer_gen: arithmetic frame model checked every cycle, plus literal frame timings.
module tb_rx_bit_timer_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [13:0] bp  = '0;
    logic [3:0]  ds  = '0;
    logic        ts  = 1'b0;
    logic        ms  = 1'b0;
    logic        par = 1'b0;
    logic        shift, pd, busy;
    logic [5:0]  idx;

    always #5 clk = ~clk;

    rx_bit_timer_gen #(.CNT_W(14), .SIZE_W(4), .DEF_PERIOD(10), .DEF_SIZE(8)) dut (
        .clk_i(clk), .rst_i(rst), .enable_timer_i(en), .bit_period_i(bp), .data_size_i(ds),
        .two_stop_i(ts), .mid_sample_i(ms),
`ifdef RX_TIMER_PARITY_EN
        .parity_en_i(par),
`endif
        .shift_enable_o(shift), .packet_done_o(pd), .bit_index_o(idx), .busy_o(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a frame is its start edge plus (P, T_first, N); outputs follow from arithmetic.
    int cyc = 0, m_t0 = 0, m_P = 0, m_T = 0, m_N = 0, m_sn;
    bit m_act = 1'b0, m_vld = 1'b0;
    assign m_sn = m_T + (m_N - 1) * m_P;

    function automatic int f_p(logic [13:0] b);
        int p;
        p = (b == 0) ? 10 : int'(b);
        return (p == 1) ? 2 : p;
    endfunction

    function automatic int f_t(logic [13:0] b, logic m);
        return m ? f_p(b) + f_p(b) / 2 : f_p(b);
    endfunction

    function automatic int f_n(logic [3:0] d, logic t, logic pa);
        int n;
        n = ((d == 0) ? 8 : int'(d)) + 1 + int'(t);
`ifdef RX_TIMER_PARITY_EN
        n = n + int'(pa);
`endif
        return n;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_act <= 1'b0;
            m_vld <= 1'b0;
        end else if (!m_act) begin
            if (en) begin
                m_act <= 1'b1;
                m_vld <= 1'b1;
                m_t0  <= cyc + 1;
                m_P   <= f_p(bp);
                m_T   <= f_t(bp, ms);
                m_N   <= f_n(ds, ts, par);
            end
        end else if (!en) begin
            m_act <= 1'b0;
            // Dropping enable before the last strobe aborts: no end-of-packet pulse.
            if ((cyc + 1 - m_t0) <= m_sn) m_vld <= 1'b0;
        end
    end

    function automatic int e_shift(int d);
        if (!m_act || d < m_T) return 0;
        return (((d - m_T) % m_P) == 0 && ((d - m_T) / m_P) < m_N) ? 1 : 0;
    endfunction

    function automatic int e_idx(int d);
        int k;
        if (!m_act || d <= m_T) return 0;
        k = (d - m_T - 1) / m_P + 1;
        return (k > m_N) ? m_N : k;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_shift", int'(shift), e_shift(cyc - m_t0));
            check("m_index", int'(idx), e_idx(cyc - m_t0));
            check("m_busy", int'(busy), (m_act && (cyc - m_t0) < m_sn) ? 1 : 0);
            check("m_done", int'(pd), (m_vld && (cyc - m_t0) == m_sn + 1) ? 1 : 0);
        end
    end

    // Runs one frame from its start edge and pins strobe/done timing to literal values.
    task automatic frame(string nm, int p, int d, int t, int m, int pa,
                         int ef, int el, int en_n, int epd, bit at_negedge);
        int first, last, cnt, pdc, extra;
        if (!at_negedge) @(negedge clk);
        bp = 14'(p); ds = 4'(d); ts = 1'(t); ms = 1'(m); par = 1'(pa); en = 1'b1;
        @(posedge clk);
        first = -1; last = -1; cnt = 0; pdc = -1;
        for (int k = 0; k < 400 && pdc < 0; k++) begin
            @(negedge clk);
            if (shift) begin
                if (first < 0) first = k;
                last = k;
                cnt++;
            end
            if (pd) begin
                pdc = k;
                check({nm, "/index_at_done"}, int'(idx), en_n);
            end
            if (k == 0) begin
                bp = 14'($urandom_range(0, 50)); ds = 4'($urandom_range(0, 15));
                ts = ~ts; ms = ~ms; par = ~par;
            end
        end
        check({nm, "/first"}, first, ef);
        check({nm, "/last"}, last, el);
        check({nm, "/count"}, cnt, en_n);
        check({nm, "/done_at"}, pdc, epd);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (shift || pd) extra++;
        end
        check({nm, "/held_quiet"}, extra, 0);
        check({nm, "/held_index"}, int'(idx), en_n);
        en = 1'b0;
        @(negedge clk);
        check({nm, "/idle_index"}, int'(idx), 0);
    endtask

    initial begin
        int first, cnt, hold;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset/shift", int'(shift), 0);
        check("reset/done", int'(pd), 0);
        check("reset/index", int'(idx), 0);
        check("reset/busy", int'(busy), 0);

        frame("p10_mid", 10, 8, 0, 1, 0, 15, 95, 9, 96, 1'b0);
        frame("defaults", 0, 0, 1, 0, 0, 10, 100, 10, 101, 1'b0);
        frame("p1", 1, 1, 0, 1, 0, 3, 5, 2, 6, 1'b0);
`ifdef RX_TIMER_PARITY_EN
        frame("parity_on", 4, 2, 0, 0, 1, 4, 16, 4, 17, 1'b0);
        frame("parity_off", 4, 2, 0, 0, 0, 4, 12, 3, 13, 1'b0);
`endif

        // Abort at cycle 22, re-enable so the new frame starts at edge 24.
        @(negedge clk);
        bp = 14'd10; ds = 4'd8; ts = 1'b0; ms = 1'b1; par = 1'b0; en = 1'b1;
        @(posedge clk);
        first = -1;
        for (int k = 0; k <= 22; k++) begin
            @(negedge clk);
            if (shift && first < 0) first = k;
            if (k == 22) en = 1'b0;
        end
        check("abort/first", first, 15);
        @(negedge clk);
        check("abort/index", int'(idx), 0);
        check("abort/busy", int'(busy), 0);
        frame("abort_restart", 10, 8, 0, 1, 0, 15, 95, 9, 96, 1'b1);

        // Reset mid-frame with the 5th strobe pending.
        @(negedge clk);
        bp = 14'd10; ds = 4'd8; ts = 1'b0; ms = 1'b1; en = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 50; k++) begin
            @(negedge clk);
            if (k == 50) begin
                check("prereset/index", int'(idx), 4);
                rst = 1'b1;
            end
        end
        @(negedge clk);
        check("midreset/shift", int'(shift), 0);
        check("midreset/done", int'(pd), 0);
        check("midreset/index", int'(idx), 0);
        check("midreset/busy", int'(busy), 0);
        rst = 1'b0; en = 1'b0;
        cnt = 0;
        repeat (70) begin
            @(negedge clk);
            if (shift || pd) cnt++;
        end
        check("midreset/quiet", cnt, 0);

        // Random frames: random configs, aborts, mid-frame config churn, occasional reset pulses.
        for (int it = 0; it < 50; it++) begin
            @(negedge clk);
            bp = 14'($urandom_range(0, 12)); ds = 4'($urandom_range(0, 6));
            ts = 1'($urandom_range(0, 1)); ms = 1'($urandom_range(0, 1));
            par = 1'($urandom_range(0, 1)); en = 1'b1;
            hold = $urandom_range(1, 160);
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                rst = ($urandom_range(0, 150) == 0);
                if ($urandom_range(0, 3) == 0) begin
                    bp = 14'($urandom_range(0, 12)); ds = 4'($urandom_range(0, 6));
                    ts = 1'($urandom_range(0, 1)); ms = 1'($urandom_range(0, 1));
                    par = 1'($urandom_range(0, 1));
                end
            end
            @(negedge clk);
            rst = 1'b0; en = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
